// File: rtl/load_store_unit.sv
// RV32I load/store unit: single-port memory sequencer with
// byte-lane steering, load extension and misalignment trap.
module load_store_unit #(
   parameter int ADDR_WIDTH = 31,
   parameter int DATA_WIDTH = 31
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic                  i_is_store,
   input  logic [2:0]            i_funct3,
   input  logic [ADDR_WIDTH:0]   i_addr,
   input  logic [DATA_WIDTH:0]   i_store_data,
   input  logic [4:0]            i_rd,
   output logic                  o_read_req,
   output logic [ADDR_WIDTH:0]   o_read_addr,
   input  logic [DATA_WIDTH:0]   i_read_data,
   output logic                  o_write_enable,
   output logic [3:0]            o_byte_enable,
   output logic [ADDR_WIDTH:0]   o_write_addr,
   output logic [DATA_WIDTH:0]   o_write_data,
   output logic                  o_wb_valid,
   output logic [4:0]            o_wb_rd,
   output logic [DATA_WIDTH:0]   o_wb_data,
   output logic                  o_misaligned
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DONE,
      ERR
   } state_t;

   state_t                state_q;
   logic                  is_store_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic [ADDR_WIDTH:0]   addr_q;
   logic [3:0]            be_q;
   logic [DATA_WIDTH:0]   wdata_q;
   logic [4:0]            rd_q;
   logic [DATA_WIDTH:0]   wb_data_q;

   logic                  mis_d;
   logic [3:0]            be_d;
   logic [DATA_WIDTH:0]   wdata_d;
   logic [DATA_WIDTH:0]   wb_data_d;
   logic [7:0]            lb;
   logic [15:0]           lh;

   always_comb begin
      mis_d = 1'b0;
      unique case (i_funct3)
         3'b000:  mis_d = 1'b0;
         3'b001:  mis_d = i_addr[0];
         3'b010:  mis_d = |i_addr[1:0];
         3'b100:  mis_d = i_is_store;
         3'b101:  mis_d = i_is_store | i_addr[0];
         default: mis_d = 1'b1;
      endcase
   end

   // Narrow stores replicate the datum so any lane picked by be_d sees it.
   always_comb begin
      be_d    = 4'b1111;
      wdata_d = i_store_data;
      unique case (i_funct3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << i_addr[1:0];
            wdata_d = {((DATA_WIDTH + 1) / 8){i_store_data[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << i_addr[1:0];
            wdata_d = {((DATA_WIDTH + 1) / 16){i_store_data[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = i_store_data;
         end
      endcase
   end

   always_comb begin
      lb        = i_read_data[{off_q, 3'b000} +: 8];
      lh        = i_read_data[{off_q[1], 4'b0000} +: 16];
      wb_data_d = i_read_data;
      unique case (funct3_q)
         3'b000:  wb_data_d = {{(DATA_WIDTH - 7){lb[7]}}, lb};
         3'b100:  wb_data_d = {{(DATA_WIDTH - 7){1'b0}}, lb};
         3'b001:  wb_data_d = {{(DATA_WIDTH - 15){lh[15]}}, lh};
         3'b101:  wb_data_d = {{(DATA_WIDTH - 15){1'b0}}, lh};
         default: wb_data_d = i_read_data;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         funct3_q   <= 3'b000;
         off_q      <= 2'b00;
         addr_q     <= '0;
         be_q       <= 4'b0000;
         wdata_q    <= '0;
         rd_q       <= 5'd0;
         wb_data_q  <= '0;
      end else if (clk_en) begin
         unique case (state_q)
            IDLE: begin
               if (i_valid) begin
                  is_store_q <= i_is_store;
                  funct3_q   <= i_funct3;
                  off_q      <= i_addr[1:0];
                  addr_q     <= {i_addr[ADDR_WIDTH:2], 2'b00};
                  be_q       <= be_d;
                  wdata_q    <= wdata_d;
                  rd_q       <= i_rd;
                  state_q    <= mis_d ? ERR : REQ;
               end
            end
            REQ:  state_q <= is_store_q ? IDLE : WAIT;
            WAIT: begin
               wb_data_q <= wb_data_d;
               state_q   <= DONE;
            end
            DONE:    state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_ready        = (state_q == IDLE);
   assign o_read_req     = (state_q == REQ) & ~is_store_q;
   assign o_write_enable = (state_q == REQ) & is_store_q;
   assign o_wb_valid     = (state_q == DONE);
   assign o_misaligned   = (state_q == ERR);
   assign o_read_addr    = addr_q;
   assign o_write_addr   = addr_q;
   assign o_write_data   = wdata_q;
   assign o_byte_enable  = o_write_enable ? be_q : 4'b0000;
   assign o_wb_rd        = rd_q;
   assign o_wb_data      = wb_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected
// memory/writeback events; a negedge monitor pops and compares.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        i_valid;
   logic        o_ready;
   logic        i_is_store;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr;
   logic [31:0] i_store_data;
   logic [4:0]  i_rd;
   logic        o_read_req;
   logic [31:0] o_read_addr;
   logic [31:0] i_read_data;
   logic        o_write_enable;
   logic [3:0]  o_byte_enable;
   logic [31:0] o_write_addr;
   logic [31:0] o_write_data;
   logic        o_wb_valid;
   logic [4:0]  o_wb_rd;
   logic [31:0] o_wb_data;
   logic        o_misaligned;

   load_store_unit #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
      .clk            (clk),
      .rst            (rst),
      .clk_en         (clk_en),
      .i_valid        (i_valid),
      .o_ready        (o_ready),
      .i_is_store     (i_is_store),
      .i_funct3       (i_funct3),
      .i_addr         (i_addr),
      .i_store_data   (i_store_data),
      .i_rd           (i_rd),
      .o_read_req     (o_read_req),
      .o_read_addr    (o_read_addr),
      .i_read_data    (i_read_data),
      .o_write_enable (o_write_enable),
      .o_byte_enable  (o_byte_enable),
      .o_write_addr   (o_write_addr),
      .o_write_data   (o_write_data),
      .o_wb_valid     (o_wb_valid),
      .o_wb_rd        (o_wb_rd),
      .o_wb_data      (o_wb_data),
      .o_misaligned   (o_misaligned)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int K_RD = 1;
   localparam int K_WR = 2;
   localparam int K_WB = 3;
   localparam int K_MIS = 4;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [4:0]  rd;
      int          cyc;
   } ev_t;

   ev_t sb[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   function automatic void push(int k, logic [31:0] a, logic [31:0] d,
                                logic [3:0] be, logic [4:0] rd, int c);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      e.be   = be;
      e.rd   = rd;
      e.cyc  = c;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin : monitor
      ev_t a;
      ev_t e;
      if (!rst && clk_en &&
          (o_read_req || o_write_enable || o_wb_valid || o_misaligned)) begin
         a.kind = 0;
         a.addr = '0;
         a.data = '0;
         a.be   = '0;
         a.rd   = '0;
         a.cyc  = cyc;
         if (o_read_req) begin
            a.kind = K_RD;
            a.addr = o_read_addr;
         end else if (o_write_enable) begin
            a.kind = K_WR;
            a.addr = o_write_addr;
            a.data = o_write_data;
            a.be   = o_byte_enable;
         end else if (o_wb_valid) begin
            a.kind = K_WB;
            a.data = o_wb_data;
            a.rd   = o_wb_rd;
         end else begin
            a.kind = K_MIS;
         end
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h cyc=%0d, required no event",
                     a.kind, a.addr, a.data, a.cyc);
         end else begin
            e = sb.pop_front();
            if (a.kind != e.kind || a.addr !== e.addr || a.data !== e.data ||
                a.be !== e.be || a.rd !== e.rd ||
                (e.cyc >= 0 && a.cyc != e.cyc)) begin
               n_bad++;
               $display("FAIL event: got kind=%0d addr=%h data=%h be=%b rd=%0d cyc=%0d, required kind=%0d addr=%h data=%h be=%b rd=%0d cyc=%0d",
                        a.kind, a.addr, a.data, a.be, a.rd, a.cyc,
                        e.kind, e.addr, e.data, e.be, e.rd, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      while (!o_ready && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout: got o_ready=0, required 1 within 50 cycles");
      end
   endtask

   // Returns e = cycle index of the first cycle after the accept edge.
   task automatic issue(input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        output int e);
      int w;
      i_valid      = 1'b1;
      i_is_store   = st;
      i_funct3     = f3;
      i_addr       = a;
      i_store_data = d;
      i_read_data  = rdata;
      i_rd         = rd;
      w = 0;
      while (!(o_ready && clk_en) && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 50) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got o_ready=0, required 1 within 50 cycles");
      end
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      e = cyc;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] mem, input logic [4:0] rd,
                          input logic [31:0] exp_ra,
                          input logic [31:0] exp_wb);
      int e;
      issue(1'b0, f3, a, 32'h0, mem, rd, e);
      push(K_RD, exp_ra, 32'h0, 4'b0000, 5'd0, e);
      push(K_WB, 32'h0, exp_wb, 4'b0000, rd, e + 2);
      wait_idle();
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_wa,
                           input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
      int e;
      issue(1'b1, f3, a, d, i_read_data, 5'd0, e);
      push(K_WR, exp_wa, exp_wd, exp_be, 5'd0, e);
   endtask

   task automatic do_bad(input logic st, input logic [2:0] f3,
                         input logic [31:0] a);
      int e;
      issue(st, f3, a, 32'h1234_5678, i_read_data, 5'd1, e);
      push(K_MIS, 32'h0, 32'h0, 4'b0000, 5'd0, e);
   endtask

   initial begin
      int e;
      int w;
      rst          = 1'b1;
      clk_en       = 1'b1;
      i_valid      = 1'b0;
      i_is_store   = 1'b0;
      i_funct3     = 3'b000;
      i_addr       = 32'h0;
      i_store_data = 32'h0;
      i_read_data  = 32'h0;
      i_rd         = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_strobes",
          {o_ready, o_read_req, o_write_enable, o_wb_valid, o_misaligned,
           o_byte_enable}, 64'h100);
      chk("reset_addrs", {o_read_addr, o_write_addr}, 64'h0);
      chk("reset_data", {o_write_data, o_wb_data}, 64'h0);
      chk("reset_rd", o_wb_rd, 64'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_load(3'b000, 32'h103, 32'h80FF_1234, 5'd5, 32'h100, 32'hFFFF_FF80);
      do_load(3'b101, 32'h202, 32'hBEEF_0000, 5'd6, 32'h200, 32'h0000_BEEF);
      do_load(3'b001, 32'h202, 32'hBEEF_0000, 5'd7, 32'h200, 32'hFFFF_BEEF);
      do_load(3'b100, 32'h101, 32'h80FF_1234, 5'd9, 32'h100, 32'h0000_0012);
      do_load(3'b000, 32'h102, 32'h80FF_1234, 5'd10, 32'h100, 32'hFFFF_FFFF);
      do_load(3'b010, 32'h10C, 32'hCAFE_F00D, 5'd0, 32'h10C, 32'hCAFE_F00D);
      do_load(3'b001, 32'h200, 32'h0001_7FFE, 5'd31, 32'h200, 32'h0000_7FFE);

      do_store(3'b000, 32'h301, 32'h0000_00AA, 32'h300, 4'b0010, 32'hAAAA_AAAA);
      do_store(3'b001, 32'h106, 32'h1234_ABCD, 32'h104, 4'b1100, 32'hABCD_ABCD);
      do_store(3'b010, 32'h108, 32'hDEAD_BEEF, 32'h108, 4'b1111, 32'hDEAD_BEEF);

      do_bad(1'b0, 3'b010, 32'h102);
      do_bad(1'b1, 3'b100, 32'h010);
      do_bad(1'b0, 3'b011, 32'h020);
      do_bad(1'b1, 3'b001, 32'h101);
      do_bad(1'b0, 3'b001, 32'h203);
      // Held behind the ERR cycle: must not be taken until o_ready returns.
      do_store(3'b000, 32'h003, 32'h0000_0055, 32'h000, 4'b1000, 32'h5555_5555);
      wait_idle();

      // Store strobe held across a clk_en gap.
      issue(1'b1, 3'b010, 32'h010, 32'h55AA_33CC, i_read_data, 5'd0, e);
      push(K_WR, 32'h010, 32'h55AA_33CC, 4'b1111, 5'd0, e + 2);
      clk_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("frozen_store_strobe", {o_write_enable, o_byte_enable, o_ready},
          64'b1_1111_0);
      clk_en = 1'b1;
      wait_idle();

      // Load frozen in WAIT for three cycles.
      issue(1'b0, 3'b001, 32'h204, 32'h0, 32'h1234_8001, 5'd3, e);
      push(K_RD, 32'h204, 32'h0, 4'b0000, 5'd0, e);
      push(K_WB, 32'h0, 32'hFFFF_8001, 4'b0000, 5'd3, e + 5);
      @(posedge clk);
      #1;
      clk_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("frozen_wait", {o_ready, o_wb_valid, o_read_req}, 64'h0);
      clk_en = 1'b1;
      wait_idle();

      // Reset (with clk_en low) while a load sits in WAIT.
      issue(1'b0, 3'b010, 32'h110, 32'h0, 32'h1111_1111, 5'd4, e);
      push(K_RD, 32'h110, 32'h0, 4'b0000, 5'd0, e);
      @(posedge clk);
      #1;
      rst    = 1'b1;
      clk_en = 1'b0;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      clk_en = 1'b1;
      chk("abort_ready", {o_ready, o_wb_valid, o_wb_rd}, 64'b1_0_00000);
      repeat (6) @(posedge clk);
      #1;

      do_load(3'b100, 32'h003, 32'hA5C3_0000, 5'd12, 32'h000, 32'h0000_00A5);

      w = 0;
      while (sb.size() != 0 && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("scoreboard_drained", sb.size(), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 31, MSB index of byte address buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 31, MSB index of data buses.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clk_en  input  1  global advance enable; when low all state and registers hold.
REQ-006 i_valid  input  1  decoded memory op present.
REQ-007 o_ready  output  1  unit can accept op; high only in IDLE.
REQ-008 i_is_store  input  1  1 = store, 0 = load.
REQ-009 i_funct3  input  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 i_addr  input  ADDR_WIDTH+1  effective byte address (rs1+imm, computed upstream).
REQ-011 i_store_data  input  DATA_WIDTH+1  rs2 value.
REQ-012 i_rd  input  5  load destination register.
REQ-013 o_read_req, o_read_addr  output  1, ADDR_WIDTH+1  memory read strobe, word-aligned address.
REQ-014 i_read_data  input  DATA_WIDTH+1  read word, valid the cycle after o_read_req.
REQ-015 o_write_enable, o_byte_enable, o_write_addr, o_write_data  output  1, 4, ADDR_WIDTH+1, DATA_WIDTH+1  memory write port.
REQ-016 o_wb_valid, o_wb_rd, o_wb_data  output  1, 5, DATA_WIDTH+1  load writeback.
REQ-017 o_misaligned  output  1  one-cycle misaligned-access exception pulse.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, DONE, ERR; transitions only on clk_en-qualified edges.
REQ-019 Accept SHALL occur on an edge where state=IDLE, i_valid=1, clk_en=1; op, addr, data, funct3, rd captured into registers.
REQ-020 Misaligned: H/HU with addr[0]=1, W with addr[1:0]!=0, or store funct3 not in {000,001,010}, or load funct3 in {011,110,111}; accept SHALL go IDLE->ERR, no memory strobe issued.
REQ-021 ERR SHALL assert o_misaligned=1 for exactly one enabled cycle, then ->IDLE.
REQ-022 Aligned accept SHALL go IDLE->REQ.
REQ-023 REQ, store: o_write_enable=1, o_write_addr={addr[ADDR_WIDTH:2],2'b00}, then ->IDLE; no o_wb_valid.
REQ-024 Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-025 Store data: SB byte replicated in all 4 lanes; SH halfword replicated in both halves; SW unchanged.
REQ-026 REQ, load: o_read_req=1, o_read_addr word-aligned, then ->WAIT.
REQ-027 WAIT: i_read_data SHALL be registered at end of the cycle, then ->DONE.
REQ-028 DONE: o_wb_valid=1 for one cycle, o_wb_rd=captured rd, then ->IDLE.
REQ-029 Load data: select byte lane addr[1:0] or halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-030 Load latency SHALL be: accept edge N, o_read_req during cycle N+1, o_wb_valid during cycle N+3 (all clk_en=1).
REQ-031 Store latency: write strobe during cycle N+1; o_ready high again in cycle N+2.
REQ-032 Strobes (o_read_req, o_write_enable, o_wb_valid, o_misaligned) SHALL be decoded from state only; all other times 0.
REQ-033 clk_en=0: state, registers and outputs SHALL hold; a strobe active when clk_en falls remains asserted until the next enabled edge.
REQ-034 Load with rd=0 SHALL still perform the read and pulse o_wb_valid with o_wb_rd=0.
REQ-035 i_valid while o_ready=0 SHALL be ignored; upstream holds op until accepted.

Reset
REQ-036 rst=1 on a clock edge SHALL force IDLE regardless of clk_en or current state, aborting any in-flight op.
REQ-037 After reset: o_ready=1; o_read_req, o_write_enable, o_wb_valid, o_misaligned=0; o_byte_enable=0; addr/data/rd outputs=0.
REQ-038 Reset during REQ SHALL deassert the strobe the following cycle; no writeback for the aborted op.

Verification
REQ-039 LB addr 0x103, mem word 0x80FF_1234 -> o_read_addr 0x100 at N+1; o_wb_data 0xFFFF_FF80 at N+3.
REQ-040 LHU addr 0x202, mem 0xBEEF_0000 -> o_wb_data 0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-041 SB addr 0x301, data 0x0000_00AA -> o_byte_enable 4'b0010, o_write_data 0xAAAA_AAAA, o_write_addr 0x300, no o_wb_valid.
REQ-042 LW addr 0x102 -> o_misaligned pulse one cycle, no o_read_req, o_ready back next cycle.
REQ-043 Load accepted, clk_en low 3 cycles during WAIT -> state frozen; o_wb_valid appears 1 enabled cycle after clk_en returns, data correct.
REQ-044 rst asserted in WAIT of a load -> next cycle IDLE, o_ready=1, o_wb_valid never asserted for that load.
